bcd_a_binario: RTL

Sequential converter from four packed BCD digits (units, tens, hundreds, thousands) to a 16-bit unsigned binary value, using shift-right / subtract-3 (reverse double dabble). It is the inverse of the calculator's binary-to-BCD path. It sits between keypad/display digit entry and the arithmetic operand inputs, and uses the same INIT/DONE start-finish handshake as the other calculator blocks.

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_a_binario_resta3_bcd.sv | 14 +
 rtl/bcd_a_binario.sv | 112 +++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and sizes for the BCD-to-binary converter.
// Fixed geometry: four BCD digits in, 16-bit binary out.
package bcd_pkg;

  typedef enum logic [1:0] {
    START,
    SHIFT,
    ADJ,
    END
  } state_t;

  localparam int N_DIG = 4;
  localparam int BIN_W = 16;
  localparam int CNT_W = 5;
  localparam int ITER  = 16;

endpackage

// File: rtl/bcd_a_binario_resta3_bcd.sv
// resta3_bcd: one-nibble correction for reverse double dabble.
// A nibble of 8 or more loses 3; smaller nibbles pass through.
module resta3_bcd (
  input  logic [3:0] d,
  output logic [3:0] q
);

  // Subtract-3 correction, no borrow out of the nibble
  always_comb begin
    q = d;
    if (d >= 4'd8) q = d - 4'd3;
  end

endmodule

// File: rtl/bcd_a_binario.sv
// bcd_a_binario: 4-digit packed BCD to 16-bit binary, shift-right/sub-3.
// Optional invalid-digit detection when BCD_CHECK_EN is defined.
module bcd_a_binario
  import bcd_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        INIT,
  input  logic [3:0]  UNIT,
  input  logic [3:0]  DEC,
  input  logic [3:0]  CENT,
  input  logic [3:0]  MIL,
  output logic [15:0] BIN,
  output logic        DONE,
  output logic        BUSY,
  output logic        ERR
);

  state_t             st_q;
  logic [BIN_W-1:0]   bcd_q;
  logic [BIN_W-1:0]   bin_q;
  logic [BIN_W-1:0]   bcd_adj;
  logic [CNT_W-1:0]   cnt_q;
  logic               done_q;
  logic               busy_q;
  logic               err_q;
  logic               bad;

  genvar g;
  generate
    for (g = 0; g < N_DIG; g++) begin : g_adj
      resta3_bcd u_r3 (
        .d (bcd_q[4*g +: 4]),
        .q (bcd_adj[4*g +: 4])
      );
    end
  endgenerate

`ifdef BCD_CHECK_EN
  // Any digit above 9 aborts the conversion
  always_comb begin
    bad = (UNIT > 4'd9) || (DEC > 4'd9) ||
          (CENT > 4'd9) || (MIL > 4'd9);
  end
`else
  // No detection: ERR stays at 0
  always_comb begin
    bad = 1'b0;
  end
`endif

  // FSM with datapath, counter and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st_q   <= START;
      bcd_q  <= '0;
      bin_q  <= '0;
      cnt_q  <= '0;
      BIN    <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (st_q)
        START: begin
          if (INIT) begin
            bcd_q  <= {MIL, CENT, DEC, UNIT};
            bin_q  <= '0;
            err_q  <= bad;
            busy_q <= 1'b1;
            if (bad) begin
              // One ADJ with count 0 writes the
              // cleared binary register to BIN
              cnt_q <= '0;
              st_q  <= ADJ;
            end else begin
              cnt_q <= CNT_W'(ITER);
              st_q  <= SHIFT;
            end
          end
        end
        SHIFT: begin
          {bcd_q, bin_q} <=
            {1'b0, bcd_q, bin_q[BIN_W-1:1]};
          cnt_q <= cnt_q - 1'b1;
          st_q  <= ADJ;
        end
        ADJ: begin
          bcd_q <= bcd_adj;
          if (cnt_q == '0) begin
            BIN    <= bin_q;
            done_q <= 1'b1;
            st_q   <= END;
          end else begin
            st_q <= SHIFT;
          end
        end
        END: begin
          busy_q <= 1'b0;
          st_q   <= START;
        end
        default: st_q <= START;
      endcase
    end
  end

  assign DONE = done_q;
  assign BUSY = busy_q;
  assign ERR  = err_q;

endmodule
